// File: rtl/serdesphy_cdr_pkg.sv
// rtl/serdesphy_cdr_pkg.sv - shared types and constants for the CDR loop filter
package serdesphy_cdr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_TRACK   = 2'd2
    } cdr_state_e;

    localparam logic [7:0] CDR_CTRL_MID = 8'd128;
    localparam logic [7:0] CDR_CTRL_MIN = 8'd0;
    localparam logic [7:0] CDR_CTRL_MAX = 8'd255;

    typedef logic signed [1:0] vote_t;

    localparam vote_t VOTE_NEG  = 2'sb11;
    localparam vote_t VOTE_ZERO = 2'sb00;
    localparam vote_t VOTE_POS  = 2'sb01;

    // Early and late together is a valid but neutral vote.
    function automatic vote_t decode_vote(input logic valid, input logic early, input logic late);
        if (valid && late && !early)
            return VOTE_POS;
        else if (valid && early && !late)
            return VOTE_NEG;
        return VOTE_ZERO;
    endfunction

endpackage

// File: rtl/serdesphy_cdr_lock_detect.sv
// rtl/serdesphy_cdr_lock_detect.sv - windowed net-vote accumulator producing quiet/loud flags
module serdesphy_cdr_lock_detect
    import serdesphy_cdr_pkg::*;
#(
    parameter int LOCK_WIN    = 64,
    parameter int LOCK_THRESH = 8
) (
    input  logic  clk,
    input  logic  rst,
    input  vote_t vote,
    input  logic  valid,
    input  logic  clear,
    input  logic  in_track,
    output logic  win_close,
    output logic  quiet,
    output logic  loud
);

    localparam int CNT_W = $clog2(LOCK_WIN);
    localparam int NET_W = CNT_W + 1;
    localparam logic [NET_W:0] QUIET_LIM = (NET_W+1)'(LOCK_THRESH);
    localparam logic [NET_W:0] LOUD_LIM  = (NET_W+1)'(2 * LOCK_THRESH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LOCK_WIN - 1);

    logic [CNT_W-1:0]        r_cnt;
    logic signed [NET_W-1:0] r_net;

    logic signed [NET_W:0] w_net_sum;
    logic [NET_W:0]        w_net_abs;
    logic                  w_last;

    // The register only ever holds LOCK_WIN-1 votes; the closing vote is
    // evaluated one bit wider so a full window of identical votes fits.
    assign w_net_sum = {r_net[NET_W-1], r_net} + {{(NET_W-1){vote[1]}}, vote};
    assign w_net_abs = w_net_sum[NET_W] ? unsigned'(-w_net_sum) : unsigned'(w_net_sum);
    assign w_last    = (r_cnt == LAST_CNT);

    assign win_close = valid & w_last;
    assign quiet     = win_close & (w_net_abs <= QUIET_LIM);
    assign loud      = win_close & in_track & (w_net_abs > LOUD_LIM);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cnt <= '0;
            r_net <= '0;
        end else if (valid) begin
            if (w_last) begin
                r_cnt <= '0;
                r_net <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
                r_net <= w_net_sum[NET_W-1:0];
            end
        end
    end

endmodule

// File: rtl/serdesphy_cdr_loop_filter.sv
// rtl/serdesphy_cdr_loop_filter.sv - bang-bang CDR PI loop filter with gain scheduling and lock detect
module serdesphy_cdr_loop_filter
    import serdesphy_cdr_pkg::*;
#(
    parameter int INT_W       = 16,
    parameter int KI_SHIFT    = 4,
    parameter int KP_ACQ      = 4,
    parameter int KP_TRK      = 1,
    parameter int LOCK_WIN    = 64,
    parameter int LOCK_THRESH = 8,
    parameter int LOCK_COUNT  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    freeze,
    input  logic                    pd_valid,
    input  logic                    pd_early,
    input  logic                    pd_late,
    output logic [7:0]              cdr_control,
    output logic                    cdr_locked,
    output logic [1:0]              cdr_state,
    output logic signed [INT_W-1:0] integ_out
);

    localparam int SUM_W = INT_W + 2;
    localparam int QC_W  = $clog2(LOCK_COUNT + 1);
    localparam logic signed [INT_W:0] SAT_HI = (INT_W+1)'((2 ** (INT_W - 1)) - 1);
    localparam logic signed [INT_W:0] SAT_LO = -SAT_HI;
    localparam logic signed [SUM_W-1:0] CTRL_HI = SUM_W'(CDR_CTRL_MAX);
    localparam logic [QC_W-1:0] QC_LAST = QC_W'(LOCK_COUNT - 1);

    cdr_state_e              r_state;
    logic signed [INT_W-1:0] r_integ;
    logic signed [7:0]       r_prop;
    logic [7:0]              r_ctrl;
    logic                    r_locked;
    logic [QC_W-1:0]         r_quiet_cnt;

    vote_t                   w_vote;
    logic                    w_valid;
    logic                    w_win_close;
    logic                    w_quiet;
    logic                    w_loud;
    logic signed [INT_W:0]   w_integ_sum;
    logic signed [INT_W-1:0] w_integ_next;
    logic signed [7:0]       w_kp;
    logic signed [7:0]       w_prop_next;
    logic signed [SUM_W-1:0] w_ctrl_sum;
    logic [7:0]              w_ctrl_next;

    assign w_vote  = decode_vote(pd_valid, pd_early, pd_late);
    assign w_valid = enable & !freeze & pd_valid & (r_state != ST_IDLE);

    serdesphy_cdr_lock_detect #(
        .LOCK_WIN    (LOCK_WIN),
        .LOCK_THRESH (LOCK_THRESH)
    ) u_lock_detect (
        .clk       (clk),
        .rst       (rst),
        .vote      (w_vote),
        .valid     (w_valid),
        .clear     (!enable),
        .in_track  (r_state == ST_TRACK),
        .win_close (w_win_close),
        .quiet     (w_quiet),
        .loud      (w_loud)
    );

    assign w_integ_sum  = {r_integ[INT_W-1], r_integ} + {{(INT_W-1){w_vote[1]}}, w_vote};
    assign w_integ_next = (w_integ_sum > SAT_HI) ? SAT_HI[INT_W-1:0] :
                          (w_integ_sum < SAT_LO) ? SAT_LO[INT_W-1:0] :
                                                   w_integ_sum[INT_W-1:0];

    assign w_kp        = (r_state == ST_TRACK) ? 8'(KP_TRK) : 8'(KP_ACQ);
    assign w_prop_next = (w_vote == VOTE_POS) ? w_kp :
                         (w_vote == VOTE_NEG) ? -w_kp : 8'sd0;

    // Control word is built from the registered integ/prop, so a vote
    // reaches cdr_control one edge after it reaches the integrator.
    assign w_ctrl_sum = $signed(SUM_W'(CDR_CTRL_MID))
                      + $signed({{2{r_integ[INT_W-1]}}, r_integ >>> KI_SHIFT})
                      + $signed({{(SUM_W-8){r_prop[7]}}, r_prop});
    assign w_ctrl_next = w_ctrl_sum[SUM_W-1]     ? CDR_CTRL_MIN :
                         (w_ctrl_sum > CTRL_HI)  ? CDR_CTRL_MAX :
                                                   w_ctrl_sum[7:0];

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            r_state     <= ST_IDLE;
            r_integ     <= '0;
            r_prop      <= '0;
            r_ctrl      <= CDR_CTRL_MID;
            r_locked    <= 1'b0;
            r_quiet_cnt <= '0;
        end else begin
            r_ctrl <= w_ctrl_next;
            r_prop <= w_valid ? w_prop_next : 8'sd0;
            if (w_valid)
                r_integ <= w_integ_next;

            case (r_state)
                ST_IDLE: begin
                    if (!freeze)
                        r_state <= ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    if (w_quiet) begin
                        if (r_quiet_cnt == QC_LAST) begin
                            r_state     <= ST_TRACK;
                            r_locked    <= 1'b1;
                            r_quiet_cnt <= '0;
                        end else begin
                            r_quiet_cnt <= r_quiet_cnt + 1'b1;
                        end
                    end else if (w_win_close) begin
                        r_quiet_cnt <= '0;
                    end
                end
                ST_TRACK: begin
                    if (w_loud) begin
                        r_state     <= ST_ACQUIRE;
                        r_locked    <= 1'b0;
                        r_quiet_cnt <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cdr_control = r_ctrl;
    assign cdr_locked  = r_locked;
    assign cdr_state   = r_state;
    assign integ_out   = r_integ;

endmodule
